// File: rtl/pit_if.sv
// pit_if: host-side bus of one interval timer channel; carries latch only when PIT_LATCH_EN is defined
interface pit_if #(parameter int WIDTH = 16);
  logic cs, load, gate, out;
  logic [1:0] mode;
  logic [WIDTH-1:0] count_in, count_out;
`ifdef PIT_LATCH_EN
  logic latch;
  modport master(output cs, load, mode, count_in, gate, latch, input out, count_out);
  modport slave(input cs, load, mode, count_in, gate, latch, output out, count_out);
`else
  modport master(output cs, load, mode, count_in, gate, input out, count_out);
  modport slave(input cs, load, mode, count_in, gate, output out, count_out);
`endif
endinterface

// File: rtl/pit_counter.sv
// pit_counter: one 8254-style down-counter channel, modes 0-3; PIT_LATCH_EN adds a count_out freeze latch
module pit_counter #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst,
  pit_if.slave bus
);
  localparam logic [WIDTH-1:0] one = WIDTH'(1);
  localparam logic [WIDTH-1:0] two = WIDTH'(2);
  logic [WIDTH-1:0] ce, init_r, half_hi, half_lo;
  logic [WIDTH:0] n_ext;
  logic [1:0] mode_r;
  logic armed, pend, gate_q, out_r, accept, rise;
  assign accept = bus.cs & bus.load;
  assign rise = bus.gate & ~gate_q;
  // a zero count stands for 2^WIDTH, so square-wave halves are taken one bit wider
  assign n_ext = init_r == '0 ? {1'b1, {WIDTH{1'b0}}} : {1'b0, init_r};
  assign half_lo = n_ext[WIDTH:1];
  assign half_hi = half_lo + {{(WIDTH-1){1'b0}}, n_ext[0]};
  assign bus.out = out_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      ce <= '0;
      init_r <= '0;
      mode_r <= '0;
      armed <= 1'b0;
      pend <= 1'b0;
      gate_q <= 1'b1;
      out_r <= 1'b1;
    end else begin
      gate_q <= bus.gate;
      if (accept) begin
        init_r <= bus.count_in;
        mode_r <= bus.mode;
        armed <= 1'b1;
        pend <= 1'b1;
        out_r <= bus.mode != 2'd0;
      end else if (armed) begin
        if (mode_r[1] && init_r == one) begin
          ce <= one;
          out_r <= 1'b1;
          pend <= 1'b0;
        end else begin
          case (mode_r)
            2'd0: if (bus.gate) begin
              ce <= pend ? init_r : ce - one;
              pend <= 1'b0;
              if (!pend && ce == one) out_r <= 1'b1;
            end
            2'd1: if (rise) begin
              ce <= init_r;
              out_r <= 1'b0;
              pend <= 1'b0;
            end else if (!pend && !out_r) begin
              ce <= ce - one;
              if (ce == one) out_r <= 1'b1;
            end
            2'd2: if (pend || rise) begin
              ce <= init_r;
              pend <= 1'b0;
              out_r <= 1'b1;
            end else if (!bus.gate) out_r <= 1'b1;
            else if (ce == one) begin
              ce <= init_r;
              out_r <= 1'b1;
            end else begin
              ce <= ce - one;
              out_r <= ce != two;
            end
            default: if (pend || rise) begin
              ce <= half_hi;
              pend <= 1'b0;
              out_r <= 1'b1;
            end else if (!bus.gate) out_r <= 1'b1;
            else if (ce == one) begin
              ce <= out_r ? half_lo : half_hi;
              out_r <= ~out_r;
            end else ce <= ce - one;
          endcase
        end
      end
    end
  end
`ifdef PIT_LATCH_EN
  logic latched;
  logic [WIDTH-1:0] snap;
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      latched <= 1'b0;
      snap <= '0;
    end else if (bus.latch) begin
      latched <= 1'b1;
      snap <= ce;
    end
  end
  assign bus.count_out = latched ? snap : ce;
`else
  assign bus.count_out = ce;
`endif
endmodule

// File: tb/tb_pit_counter.sv
// tb_pit_counter: directed and random stimulus against a phase-position reference model of one timer channel
module tb_pit_counter;
  localparam int W = 4;
  localparam int M = 1 << W;
  logic clk = 1'b0, rst = 1'b1;
  int total = 0, passed = 0, failed = 0;
  int m_mode = 0, nn = 1, k = 0, pos = 0, m_ce = 0, snap = 0;
  bit armed = 0, pend = 0, trig = 0, goff = 0, gq = 1, m_out = 1, latched = 0;
  always #5 clk = ~clk;
  pit_if #(.WIDTH(W)) bus();
  pit_counter #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // model: elapsed-edge count (modes 0/1) or position within the period (modes 2/3)
  task automatic model_edge();
    bit rise;
    int h;
    rise = bus.gate && !gq;
    if (rst) begin
      armed = 0; m_out = 1; m_ce = 0; gq = 1; pend = 0; m_mode = 0; latched = 0;
      return;
    end
    gq = bus.gate;
    if (bus.cs && bus.load) begin
      armed = 1; pend = 1; trig = 0; latched = 0;
      m_mode = int'(bus.mode);
      nn = bus.count_in == '0 ? M : int'(bus.count_in);
      m_out = bus.mode != 2'd0;
      return;
    end
`ifdef PIT_LATCH_EN
    if (bus.latch) begin
      latched = 1;
      snap = m_ce;
    end
`endif
    if (!armed) return;
    if (m_mode >= 2 && nn == 1) begin
      m_ce = 1; m_out = 1; pend = 0;
      return;
    end
    if (m_mode == 0) begin
      if (bus.gate) begin
        if (pend) begin pend = 0; k = 0; end
        else k++;
        m_ce = ((nn - k) % M + M) % M;
        m_out = k >= nn;
      end
    end else if (m_mode == 1) begin
      if (rise) begin trig = 1; k = 0; end
      else if (trig) k++;
      if (trig) begin
        m_ce = k >= nn ? 0 : (nn - k) % M;
        m_out = k >= nn;
      end
    end else begin
      if (pend || rise) begin pend = 0; pos = 0; goff = 0; end
      else if (!bus.gate) goff = 1;
      else begin pos = (pos + 1) % nn; goff = 0; end
      h = (nn + 1) / 2;
      if (m_mode == 2) begin
        m_ce = (nn - pos) % M;
        m_out = goff || pos != nn - 1;
      end else begin
        m_ce = pos < h ? h - pos : nn - pos;
        m_out = goff || pos < h;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("out", 32'(bus.out), 32'(m_out));
    chk("count_out", 32'(bus.count_out), 32'(latched ? snap : m_ce));
  endtask

  task automatic do_load(input int md, input int n);
    bus.cs = 1'b1;
    bus.load = 1'b1;
    bus.mode = 2'(md);
    bus.count_in = W'(n);
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    int hi;
    bus.cs = 1'b0; bus.load = 1'b0; bus.mode = 2'd0; bus.count_in = '0; bus.gate = 1'b1;
`ifdef PIT_LATCH_EN
    bus.latch = 1'b0;
`endif
    tick(); tick();
    chk("reset_out", 32'(bus.out), 32'd1);
    chk("reset_count", 32'(bus.count_out), 32'd0);
    rst = 1'b0;
    bus.cs = 1'b0; bus.load = 1'b1; bus.count_in = W'(5);
    tick(); tick();
    bus.load = 1'b0;
    chk("ignored_load", 32'(bus.count_out), 32'd0);
    // mode 0, N=5, gate high
    do_load(0, 5);
    chk("m0_out_at_load", 32'(bus.out), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("m0_count", 32'(bus.count_out), 32'(5 - i));
      chk("m0_out", 32'(bus.out), 32'(i == 5));
    end
    // mode 0, N=8, gate low on two edges mid-count
    do_load(0, 8);
    for (int i = 1; i <= 11; i++) begin
      bus.gate = !(i == 4 || i == 5);
      tick();
      if (i == 5) chk("m0_gated_hold", 32'(bus.count_out), 32'd6);
      if (i == 10) chk("m0_gated_out_low", 32'(bus.out), 32'd0);
      if (i == 11) chk("m0_gated_out_high", 32'(bus.out), 32'd1);
    end
    // mode 1, N=4, retrigger two edges after the first trigger
    bus.gate = 1'b0;
    do_load(1, 4);
    tick();
    chk("m1_wait_out", 32'(bus.out), 32'd1);
    bus.gate = 1'b1; tick();
    chk("m1_trig_out", 32'(bus.out), 32'd0);
    bus.gate = 1'b0; tick();
    bus.gate = 1'b1; tick();
    bus.gate = 1'b0;
    tick(); tick(); tick();
    chk("m1_out_t5", 32'(bus.out), 32'd0);
    tick();
    chk("m1_out_t6", 32'(bus.out), 32'd1);
    chk("m1_count_t6", 32'(bus.count_out), 32'd0);
    tick();
    // mode 2, N=4: one low clock per period, gate low forces high
    bus.gate = 1'b1;
    do_load(2, 4);
    tick();
    hi = 0;
    for (int i = 0; i < 12; i++) begin tick(); hi += int'(bus.out); end
    chk("m2_high_edges", 32'(hi), 32'd9);
    bus.gate = 1'b0;
    repeat (3) tick();
    bus.gate = 1'b1;
    repeat (9) tick();
    // mode 3, N=5 and N=0
    do_load(3, 5);
    hi = 0;
    for (int i = 0; i < 10; i++) begin tick(); hi += int'(bus.out); end
    chk("m3_n5_high_edges", 32'(hi), 32'd6);
    do_load(3, 0);
    hi = 0;
    for (int i = 0; i < 16; i++) begin tick(); hi += int'(bus.out); end
    chk("m3_n0_high_edges", 32'(hi), 32'd8);
    repeat (18) tick();
    // N=1 is illegal in modes 2 and 3
    do_load(2, 1); repeat (4) tick();
    do_load(3, 1); repeat (4) tick();
    // reset mid-count, then a deselected load
    do_load(3, 7); repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_out", 32'(bus.out), 32'd1);
    chk("rst_count", 32'(bus.count_out), 32'd0);
    bus.cs = 1'b0; bus.load = 1'b1; bus.mode = 2'd0; bus.count_in = W'(9);
    tick();
    bus.load = 1'b0;
    repeat (3) tick();
    chk("cs0_count", 32'(bus.count_out), 32'd0);
    chk("cs0_out", 32'(bus.out), 32'd1);
`ifdef PIT_LATCH_EN
    do_load(0, 8);
    repeat (6) tick();
    bus.latch = 1'b1; tick(); bus.latch = 1'b0;
    chk("latch_snap", 32'(bus.count_out), 32'd3);
    repeat (3) tick();
    chk("latch_hold", 32'(bus.count_out), 32'd3);
    do_load(0, 6); tick();
    chk("latch_release", 32'(bus.count_out), 32'd6);
`endif
    // random phase
    do_load(2, 6);
    for (int c = 0; c < 900; c++) begin
      rst = $urandom_range(0, 299) == 0;
      bus.cs = $urandom_range(0, 3) != 0;
      bus.load = $urandom_range(0, 24) == 0;
      bus.mode = 2'($urandom_range(0, 3));
      bus.count_in = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 1)) : W'($urandom);
      if ($urandom_range(0, 5) == 0) bus.gate = ~bus.gate;
`ifdef PIT_LATCH_EN
      bus.latch = $urandom_range(0, 30) == 0;
`endif
      tick();
    end
    rst = 1'b0;
    bus.load = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pit_counter.md
# pit_counter

Parametrised programmable interval timer counter: one WIDTH-bit down-counter channel with four selectable modes (0 interrupt on terminal count, 1 retriggerable one-shot, 2 rate generator, 3 square wave). It generalises the single-mode counter 0 block and is the per-channel building block of the 8254 top level. It counts on every rising edge of `clk`, gated by `gate`, and is loaded through a chip-selected write strobe.

## Interface
- `WIDTH`, 16: counter and count-word width (≥4).
- `clk` in 1: counting clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cs` in 1: chip select; `load` ignored when 0.
- `load` in 1: one-cycle write strobe for `count_in`/`mode`.
- `mode` in 2: counter mode 0..3, sampled on accepted load.
- `count_in` in WIDTH: initial count N; N=0 means 2^WIDTH.
- `gate` in 1: gate input (level and rising-edge use per mode).
- `out` out 1: counter output.
- `count_out` out WIDTH: counting element (CE) value.

## Operation
- Reset: `out`=1, `count_out`=0, CE=0, mode_r=0, `armed`=0, `gate_q`=1 (no spurious edge). No counting until first accepted load.
- Accepted load (edge L, `cs`&`load`): init_r←N, mode_r←`mode`, `armed`←1; `out`←0 in mode 0, else `out`←1. Load mid-count aborts the current cycle.
- Gate edge: rising = `gate`&!`gate_q`; `gate_q` registered every edge.
- Mode 0: CE←N at L+1 (held if `gate`=0, loaded once `gate`=1). Then CE−1 per edge while `gate`=1; `gate`=0 holds. `out`←1 on the edge CE becomes 0; stays 1 until next load. CE wraps 0→2^WIDTH−1 and keeps decrementing.
- Mode 1: after load, wait for gate rising edge T: CE←N, `out`←0. Decrement every edge regardless of `gate` level; `out`←1 when CE becomes 0, then CE holds at 0. Gate rising edge mid-count reloads CE←N, `out` stays 0.
- Mode 2: CE←N at L+1; decrement while `gate`=1. Edge where CE goes 2→1: `out`←0. Next edge (CE=1): CE←N, `out`←1. Period N clocks, low 1 clock. `gate`=0: `out`←1 next edge, CE holds; gate rising edge: CE←N next edge.
- Mode 3: high phase H=ceil(N/2), low phase Lo=floor(N/2); N=0 gives H=Lo=2^(WIDTH−1). CE←H at L+1, `out`=1; decrement while `gate`=1; edge with CE=1: toggle `out`, CE←length of next phase. `gate`=0: `out`←1, CE holds; gate rising edge: CE←H, `out`=1.
- N=1 in modes 2/3 is illegal: `out` held 1, CE reloads 1 each edge.
- Priority per edge: `rst` > accepted load > gate-edge reload > decrement. Load and gate rising edge in the same cycle: load wins, edge discarded.

## Timing
- All outputs registered; no combinational input→output path.
- Load→first CE value: 1 edge. Mode 0 gate high throughout: `out` rises at edge L+1+N.
- Mode 1 trigger→`out` low: same edge T; `out` high at T+N.
- Mode 2/3 output period exactly N edges while `gate`=1.
- Reset asserted mid-count: all state returns to reset values on that edge; `armed`=0.

## Configuration
- `PIT_LATCH_EN` defined: adds input `latch` (1 bit). On edge with `latch`=1, `count_out`←CE and freezes; released (tracks CE live again) by next accepted load or `rst`. `latch` during a freeze re-snapshots.
- Undefined: no `latch` port; `count_out` always equals CE.

## Test plan
- Mode 0, N=5, `gate`=1, load at edge L → `out` 0 from L, `count_out` 5,4,3,2,1,0 at L+1..L+6, `out`=1 at L+6.
- Mode 0, N=8, `gate` low 2 cycles mid-count → count holds 2 edges, `out` rises 2 edges late (L+11).
- Mode 1, N=4, gate pulse at T, second pulse at T+2 → `out` low T..T+5, high at T+6.
- Mode 2, N=4, gate high → `out` low 1 clock every 4; gate low for 3 cycles → `out` high, resumes with full period after gate rise.
- Mode 3, N=5 → `out` high 3, low 2, repeating; N=0 with WIDTH=4 → 8 high, 8 low.
- `rst` mid-count and load with `cs`=0 → outputs return to reset values; ignored load leaves CE unchanged. With `PIT_LATCH_EN`: latch at CE=3 keeps `count_out`=3 while CE continues.
